// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: instruction fields, opcodes, immediate formats and
// the decoded entry carried through the stage register.
package decode_stage_pkg;

   localparam int XLEN_MAX = 64;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int RD_LSB     = 7;
   localparam int RD_MSB     = 11;
   localparam int FUNCT3_LSB = 12;
   localparam int FUNCT3_MSB = 14;
   localparam int RS1_LSB    = 15;
   localparam int RS1_MSB    = 19;
   localparam int RS2_LSB    = 20;
   localparam int RS2_MSB    = 24;
   localparam int FUNCT7_LSB = 25;
   localparam int FUNCT7_MSB = 31;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  reg_addr_t;

   typedef enum logic [6:0] {
      OPC_LOAD     = 7'h03,
      OPC_MISC_MEM = 7'h0f,
      OPC_OP_IMM   = 7'h13,
      OPC_AUIPC    = 7'h17,
      OPC_STORE    = 7'h23,
      OPC_OP       = 7'h33,
      OPC_LUI      = 7'h37,
      OPC_BRANCH   = 7'h63,
      OPC_JALR     = 7'h67,
      OPC_JAL      = 7'h6f,
      OPC_SYSTEM   = 7'h73
   } opcode_e;

   typedef enum logic [2:0] {
      F3_ADD_SUB = 3'd0,
      F3_SLL     = 3'd1,
      F3_SLT     = 3'd2,
      F3_SLTU    = 3'd3,
      F3_XOR     = 3'd4,
      F3_SRL_SRA = 3'd5,
      F3_OR      = 3'd6,
      F3_AND     = 3'd7
   } funct3_e;

   typedef enum logic [6:0] {
      F7_BASE = 7'h00,
      F7_ALT  = 7'h20
   } funct7_e;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } imm_fmt_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   // pc and imm are held at the widest XLEN; the stage truncates on output.
   typedef struct packed {
      opcode_e               op;
      reg_addr_t             rd;
      reg_addr_t             rs1;
      reg_addr_t             rs2;
      funct3_e               funct3;
      funct7_e               funct7;
      logic [XLEN_MAX-1:0]   imm;
      imm_fmt_e              imm_fmt;
      logic                  illegal;
      logic [XLEN_MAX-1:0]   pc;
   } decoded_instr_t;

   function automatic logic is_rv32i_opcode(input logic [6:0] opc);
      case (opc)
         OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
         OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of the fetch-side and execute-side signals of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
   import decode_stage_pkg::*;

   // Both sides use valid/ready: a transfer happens at a rising edge where
   // valid && ready; valid must not depend on ready, and a raised valid holds
   // its payload until the transfer. flush cancels anything in flight.
   logic              in_valid;
   logic              in_ready;
   word_t             in_instr;
   logic [XLEN-1:0]   in_pc;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_pc;
   opcode_e           op;
   reg_addr_t         rd;
   reg_addr_t         rs1;
   reg_addr_t         rs2;
   funct3_e           funct3;
   funct7_e           funct7;
   logic [XLEN-1:0]   imm;
   imm_fmt_e          imm_fmt;
   logic              illegal;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, op, rd, rs1, rs2, funct3, funct7,
             imm, imm_fmt, illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, op, rd, rs1, rs2, funct3, funct7,
             imm, imm_fmt, illegal
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate format selection and sign extension for the RV32I base set.
module decode_stage_imm_gen import decode_stage_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [31:7]      instr,
   input  opcode_e          op,
   output imm_fmt_e         imm_fmt,
   output logic [XLEN-1:0]  imm
);

   word_t imm32;

   always_comb begin
      imm_fmt = FMT_R;
      imm32   = '0;
      case (op)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
            imm_fmt = FMT_I;
            imm32   = {{20{instr[31]}}, instr[31:20]};
         end
         OPC_STORE: begin
            imm_fmt = FMT_S;
            imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OPC_BRANCH: begin
            imm_fmt = FMT_B;
            imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            imm_fmt = FMT_U;
            imm32   = {instr[31:12], 12'b0};
         end
         OPC_JAL: begin
            imm_fmt = FMT_J;
            imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
         end
         default: begin
            imm_fmt = FMT_R;
            imm32   = '0;
         end
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with an optional 2-entry skid buffer so that
// in_ready never depends combinationally on out_ready.
module decode_stage import decode_stage_pkg::*; #(
   parameter int XLEN          = 32,
   parameter int SKID_EN       = 1,
   parameter int CHECK_ILLEGAL = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   decode_stage_if.slave bus,
   output skid_state_e   skid_state
);

   decoded_instr_t  dec;
   decoded_instr_t  main_q;
   decoded_instr_t  skid_q;
   skid_state_e     state_q;
   skid_state_e     state_d;
   logic            in_ready_q;
   logic            accept;
   logic            load_main;
   logic            main_from_skid;
   logic            load_skid;
   logic            illegal_d;
   opcode_e         op_d;
   imm_fmt_e        fmt_d;
   logic [XLEN-1:0] imm_d;
   logic [2:0]      f3;
   logic [6:0]      f7;

   assign op_d = opcode_e'(bus.in_instr[OPCODE_MSB:OPCODE_LSB]);
   assign f3   = bus.in_instr[FUNCT3_MSB:FUNCT3_LSB];
   assign f7   = bus.in_instr[FUNCT7_MSB:FUNCT7_LSB];

   decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr   (bus.in_instr[31:7]),
      .op      (op_d),
      .imm_fmt (fmt_d),
      .imm     (imm_d)
   );

   always_comb begin
      illegal_d = 1'b0;
      if (bus.in_instr[1:0] != 2'b11 || !is_rv32i_opcode(bus.in_instr[6:0])) begin
         illegal_d = 1'b1;
      end else begin
         case (op_d)
            OPC_OP:
               illegal_d = (f7 != 7'h00) &&
                           !(f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            OPC_OP_IMM:
               illegal_d = (f3 == 3'd1 || f3 == 3'd5) && (f7 != 7'h00) &&
                           !(f7 == 7'h20 && f3 == 3'd5);
            OPC_JALR:   illegal_d = (f3 != 3'd0);
            OPC_BRANCH: illegal_d = (f3 == 3'd2 || f3 == 3'd3);
            default:    illegal_d = 1'b0;
         endcase
      end
   end

   always_comb begin
      dec         = '0;
      dec.op      = op_d;
      dec.rd      = bus.in_instr[RD_MSB:RD_LSB];
      dec.rs1     = bus.in_instr[RS1_MSB:RS1_LSB];
      dec.rs2     = bus.in_instr[RS2_MSB:RS2_LSB];
      dec.funct3  = funct3_e'(f3);
      dec.funct7  = funct7_e'(f7);
      dec.imm     = XLEN_MAX'($signed(imm_d));
      dec.imm_fmt = fmt_d;
      dec.illegal = (CHECK_ILLEGAL != 0) && illegal_d;
      dec.pc      = XLEN_MAX'(bus.in_pc);
   end

   assign bus.in_ready = (SKID_EN != 0) ? in_ready_q
                                        : ((state_q == ST_EMPTY) || bus.out_ready);
   assign accept = bus.in_valid && bus.in_ready;

   // ONE->TWO is only reachable with the skid buffer: without it accept implies out_ready.
   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && bus.out_ready) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_d   = ST_TWO;
               load_skid = 1'b1;
            end else if (bus.out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (bus.out_ready) begin
               state_d        = ST_ONE;
               load_main      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (bus.flush) begin
         state_d   = ST_EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_TWO);
         if (load_main) main_q <= main_from_skid ? skid_q : dec;
         if (load_skid) skid_q <= dec;
      end
   end

   assign bus.out_valid = (state_q != ST_EMPTY);
   assign bus.out_pc    = XLEN'(main_q.pc);
   assign bus.op        = main_q.op;
   assign bus.rd        = main_q.rd;
   assign bus.rs1       = main_q.rs1;
   assign bus.rs2       = main_q.rs2;
   assign bus.funct3    = main_q.funct3;
   assign bus.funct7    = main_q.funct7;
   assign bus.imm       = XLEN'(main_q.imm);
   assign bus.imm_fmt   = main_q.imm_fmt;
   assign bus.illegal   = main_q.illegal;
   assign skid_state    = state_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table, skid ordering, flush,
// reset, XLEN=64 sign extension and the SKID_EN=0 / CHECK_ILLEGAL=0 variant.
module tb_decode_stage;
   import decode_stage_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32)) b32 ();
   decode_stage_if #(.XLEN(64)) b64 ();
   decode_stage_if #(.XLEN(32)) b0 ();
   skid_state_e st32, st64, st0;

   decode_stage #(.XLEN(32), .SKID_EN(1), .CHECK_ILLEGAL(1)) u32 (
      .clk(clk), .rst_n(rst_n), .bus(b32), .skid_state(st32));
   decode_stage #(.XLEN(64), .SKID_EN(1), .CHECK_ILLEGAL(1)) u64 (
      .clk(clk), .rst_n(rst_n), .bus(b64), .skid_state(st64));
   decode_stage #(.XLEN(32), .SKID_EN(0), .CHECK_ILLEGAL(0)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(b0), .skid_state(st0));

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } vec_t;

   vec_t        vecs[15];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_cycle();
      #1;
      if (b32.out_valid && b32.out_ready) begin
         if (exp_q.size() == 0) chk("sb_underflow", 64'(b32.out_pc), 64'hdead);
         else chk("sb_order", 64'(b32.out_pc), 64'(exp_q.pop_front()));
      end
      if (b32.in_valid && b32.in_ready) exp_q.push_back(b32.in_pc);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{32'hFFF10093, 7'h13, 5'd1,  5'd2,  5'd31, 3'd0, 7'h7f, 32'hFFFFFFFF, FMT_I, 1'b0};
      vecs[1]  = '{32'h00552423, 7'h23, 5'd8,  5'd10, 5'd5,  3'd2, 7'h00, 32'h00000008, FMT_S, 1'b0};
      vecs[2]  = '{32'hFE000EE3, 7'h63, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7f, 32'hFFFFFFFC, FMT_B, 1'b0};
      vecs[3]  = '{32'h00000000, 7'h00, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, FMT_R, 1'b1};
      vecs[4]  = '{32'h40001033, 7'h33, 5'd0,  5'd0,  5'd0,  3'd1, 7'h20, 32'h00000000, FMT_R, 1'b1};
      vecs[5]  = '{32'h40005033, 7'h33, 5'd0,  5'd0,  5'd0,  3'd5, 7'h20, 32'h00000000, FMT_R, 1'b0};
      vecs[6]  = '{32'h001000EF, 7'h6f, 5'd1,  5'd0,  5'd1,  3'd0, 7'h00, 32'h00000800, FMT_J, 1'b0};
      vecs[7]  = '{32'h00009067, 7'h67, 5'd0,  5'd1,  5'd0,  3'd1, 7'h00, 32'h00000000, FMT_I, 1'b1};
      vecs[8]  = '{32'h40525193, 7'h13, 5'd3,  5'd4,  5'd5,  3'd5, 7'h20, 32'h00000405, FMT_I, 1'b0};
      vecs[9]  = '{32'h40521193, 7'h13, 5'd3,  5'd4,  5'd5,  3'd1, 7'h20, 32'h00000405, FMT_I, 1'b1};
      vecs[10] = '{32'hFE002EE3, 7'h63, 5'd29, 5'd0,  5'd0,  3'd2, 7'h7f, 32'hFFFFFFFC, FMT_B, 1'b1};
      vecs[11] = '{32'h12345297, 7'h17, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, FMT_U, 1'b0};
      vecs[12] = '{32'hFF012303, 7'h03, 5'd6,  5'd2,  5'd16, 3'd2, 7'h7f, 32'hFFFFFFF0, FMT_I, 1'b0};
      vecs[13] = '{32'h00000073, 7'h73, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, FMT_I, 1'b0};
      vecs[14] = '{32'h0000000B, 7'h0b, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, FMT_R, 1'b1};

      b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.flush = 1'b0; b32.out_ready = 1'b0;
      b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0; b64.flush = 1'b0; b64.out_ready = 1'b0;
      b0.in_valid  = 1'b0; b0.in_instr  = '0; b0.in_pc  = '0; b0.flush  = 1'b0; b0.out_ready  = 1'b0;

      // reset: one sampled clock
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
      chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
      chk("rst_op", 64'(b32.op), 64'd0);
      chk("rst_imm", 64'(b32.imm), 64'd0);
      chk("rst_pc", 64'(b32.out_pc), 64'd0);
      chk("rst_state", 64'(st32), 64'(ST_EMPTY));
      chk("rst_in_ready64", 64'(b64.in_ready), 64'd1);
      chk("rst_in_ready0", 64'(b0.in_ready), 64'd1);

      // decode table, out_ready held high
      b32.out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         b32.in_valid = 1'b1;
         b32.in_instr = vecs[i].instr;
         b32.in_pc    = 32'h1000 + 32'(4 * i);
         step();
         b32.in_valid = 1'b0;
         chk($sformatf("v%0d_valid", i), 64'(b32.out_valid), 64'd1);
         chk($sformatf("v%0d_op", i), 64'(b32.op), 64'(vecs[i].op));
         chk($sformatf("v%0d_rd", i), 64'(b32.rd), 64'(vecs[i].rd));
         chk($sformatf("v%0d_rs1", i), 64'(b32.rs1), 64'(vecs[i].rs1));
         chk($sformatf("v%0d_rs2", i), 64'(b32.rs2), 64'(vecs[i].rs2));
         chk($sformatf("v%0d_f3", i), 64'(b32.funct3), 64'(vecs[i].f3));
         chk($sformatf("v%0d_f7", i), 64'(b32.funct7), 64'(vecs[i].f7));
         chk($sformatf("v%0d_imm", i), 64'(b32.imm), 64'(vecs[i].imm));
         chk($sformatf("v%0d_fmt", i), 64'(b32.imm_fmt), 64'(vecs[i].fmt));
         chk($sformatf("v%0d_ill", i), 64'(b32.illegal), 64'(vecs[i].ill));
         chk($sformatf("v%0d_pc", i), 64'(b32.out_pc), 64'(32'h1000 + 32'(4 * i)));
      end
      step();
      chk("tbl_drain_valid", 64'(b32.out_valid), 64'd0);

      // three back-to-back entries against a stalled consumer
      b32.out_ready = 1'b0;
      b32.in_valid  = 1'b1;
      b32.in_instr  = 32'h00100093;
      b32.in_pc     = 32'h100;
      step();
      chk("bb1_in_ready", 64'(b32.in_ready), 64'd1);
      chk("bb1_state", 64'(st32), 64'(ST_ONE));
      b32.in_instr = 32'h00200093;
      b32.in_pc    = 32'h104;
      step();
      chk("bb2_in_ready", 64'(b32.in_ready), 64'd0);
      chk("bb2_state", 64'(st32), 64'(ST_TWO));
      chk("bb2_pc", 64'(b32.out_pc), 64'h100);
      b32.in_instr = 32'h00300093;
      b32.in_pc    = 32'h108;
      step();
      chk("bb3_hold_pc", 64'(b32.out_pc), 64'h100);
      chk("bb3_hold_imm", 64'(b32.imm), 64'd1);
      chk("bb3_in_ready", 64'(b32.in_ready), 64'd0);
      b32.out_ready = 1'b1;
      step();
      chk("bb4_pc", 64'(b32.out_pc), 64'h104);
      chk("bb4_imm", 64'(b32.imm), 64'd2);
      chk("bb4_in_ready", 64'(b32.in_ready), 64'd1);
      step();
      chk("bb5_pc", 64'(b32.out_pc), 64'h108);
      chk("bb5_imm", 64'(b32.imm), 64'd3);
      b32.in_valid = 1'b0;
      step();
      chk("bb6_valid", 64'(b32.out_valid), 64'd0);

      // ordering stream with a stuttering consumer
      for (int c = 0; c < 60; c++) begin
         b32.in_valid  = (c % 4 != 3);
         b32.in_instr  = 32'h00000013 | (32'(c) << 20);
         b32.in_pc     = 32'h2000 + 32'(4 * c);
         b32.out_ready = (c % 3 != 0);
         sb_cycle();
      end
      b32.in_valid  = 1'b0;
      b32.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) sb_cycle();
      chk("sb_drain_empty", 64'(exp_q.size()), 64'd0);
      chk("sb_drain_valid", 64'(b32.out_valid), 64'd0);

      // flush while the skid buffer is full
      b32.out_ready = 1'b0;
      b32.in_valid  = 1'b1;
      b32.in_instr  = 32'h00100093;
      b32.in_pc     = 32'h300;
      step();
      b32.in_pc = 32'h304;
      step();
      chk("fl_pre_state", 64'(st32), 64'(ST_TWO));
      b32.flush = 1'b1;
      b32.in_pc = 32'h308;
      step();
      chk("fl_valid", 64'(b32.out_valid), 64'd0);
      chk("fl_in_ready", 64'(b32.in_ready), 64'd1);
      chk("fl_state", 64'(st32), 64'(ST_EMPTY));
      b32.flush     = 1'b0;
      b32.in_valid  = 1'b0;
      b32.out_ready = 1'b1;
      step();
      step();
      chk("fl_post_valid", 64'(b32.out_valid), 64'd0);
      b32.in_valid = 1'b1;
      b32.in_pc    = 32'h30c;
      step();
      b32.in_valid = 1'b0;
      chk("fl_next_pc", 64'(b32.out_pc), 64'h30c);
      chk("fl_next_valid", 64'(b32.out_valid), 64'd1);

      // single register, illegal check disabled
      b0.in_valid  = 1'b1;
      b0.in_instr  = 32'h00000000;
      b0.in_pc     = 32'h40;
      b0.out_ready = 1'b0;
      step();
      b0.in_valid = 1'b0;
      chk("ns_valid", 64'(b0.out_valid), 64'd1);
      chk("ns_illegal", 64'(b0.illegal), 64'd0);
      chk("ns_in_ready_stall", 64'(b0.in_ready), 64'd0);
      b0.out_ready = 1'b1;
      #1;
      chk("ns_in_ready_comb", 64'(b0.in_ready), 64'd1);
      step();
      chk("ns_pop_valid", 64'(b0.out_valid), 64'd0);

      // XLEN=64 sign extension, then reset while full
      b64.in_valid  = 1'b1;
      b64.in_instr  = 32'h800000B7;
      b64.in_pc     = 64'hFFFF000000001000;
      b64.out_ready = 1'b0;
      step();
      chk("x64_imm", b64.imm, 64'hFFFFFFFF80000000);
      chk("x64_fmt", 64'(b64.imm_fmt), 64'(FMT_U));
      chk("x64_rd", 64'(b64.rd), 64'd1);
      chk("x64_pc", b64.out_pc, 64'hFFFF000000001000);
      b64.in_instr = 32'hFE000EE3;
      b64.in_pc    = 64'hFFFF000000001004;
      step();
      chk("x64_state_two", 64'(st64), 64'(ST_TWO));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("x64_rst_valid", 64'(b64.out_valid), 64'd0);
      chk("x64_rst_in_ready", 64'(b64.in_ready), 64'd1);
      chk("x64_rst_imm", b64.imm, 64'd0);
      b64.in_valid = 1'b0;
      step();
      chk("x64_rst_stays_empty", 64'(b64.out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
